// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with frame checking, timeout and a byte FIFO.
// Define PS2_KEY_EVENT_EN to fold E0/F0 prefixes into ext/break flags on each entry.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_data,
    output logic                          out_break,
    output logic                          out_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          timeout_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
`ifdef PS2_KEY_EVENT_EN
    localparam int W = 10;
`else
    localparam int W = 8;
`endif

    logic [SYNC_STAGES-1:0] cs, ds;
    logic                   cp;
    logic [3:0]             cnt;
    logic [9:0]             sr;
    logic [TW-1:0]          tcnt;
    logic                   push_v;
    logic [W-1:0]           push_d;
    logic [W-1:0]           mem [FIFO_DEPTH];
    logic [AW:0]            wp, rp;
    logic                   fall, done, ok, good, tmo, pfx, pop, full;
    logic [10:0]            frame;
    logic [7:0]             rx_byte;
    logic [W-1:0]           entry;
    logic [W-1:0]           head;

    assign fall    = cp & ~cs[SYNC_STAGES-1];
    // Current bit joins the ten already shifted in so the 11th edge sees the whole frame.
    assign frame   = {ds[SYNC_STAGES-1], sr};
    assign rx_byte = frame[8:1];
    assign ok      = !frame[0] && frame[10] && (^frame[9:1]);
    assign done    = fall && cnt == 4'd10;
    assign good    = done && ok;
    assign tmo     = !fall && cnt != 4'd0 && tcnt == TW'(TIMEOUT_CYCLES - 1);

`ifdef PS2_KEY_EVENT_EN
    logic ext, brk;
    assign pfx   = rx_byte == 8'hE0 || rx_byte == 8'hF0;
    assign entry = {ext, brk, rx_byte};
    always_ff @(posedge clk) begin
        if (!resetn || (done && !ok) || tmo) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (good) begin
            ext <= rx_byte == 8'hE0 ? 1'b1 : (rx_byte == 8'hF0 ? ext : 1'b0);
            brk <= rx_byte == 8'hF0 ? 1'b1 : (rx_byte == 8'hE0 ? brk : 1'b0);
        end
    end
`else
    assign pfx   = 1'b0;
    assign entry = rx_byte;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cs          <= '1;
            ds          <= '1;
            cp          <= 1'b1;
            cnt         <= 4'd0;
            sr          <= '0;
            tcnt        <= '0;
            push_v      <= 1'b0;
            push_d      <= '0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cs          <= {cs[SYNC_STAGES-2:0], ps2_clk};
            ds          <= {ds[SYNC_STAGES-2:0], ps2_data};
            cp          <= cs[SYNC_STAGES-1];
            push_v      <= good && !pfx;
            frame_err   <= done && !ok;
            timeout_err <= tmo;
            if (good)
                push_d <= entry;
            if (fall) begin
                tcnt <= '0;
                sr   <= frame[10:1];
                cnt  <= done ? 4'd0 : cnt + 4'd1;
            end else if (cnt != 4'd0) begin
                tcnt <= tmo ? '0 : tcnt + TW'(1);
                cnt  <= tmo ? 4'd0 : cnt;
            end
        end
    end

    assign fifo_count = wp - rp;
    assign out_valid  = fifo_count != '0;
    assign pop        = out_valid && out_ready;
    assign full       = fifo_count == FULL;
    assign head       = mem[rp[AW-1:0]];
    assign out_data   = head[7:0];
`ifdef PS2_KEY_EVENT_EN
    assign out_ext    = head[9];
    assign out_break  = head[8];
`else
    assign out_ext    = 1'b0;
    assign out_break  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            overflow <= push_v && full && !pop;
            if (pop)
                rp <= rp + (AW+1)'(1);
            if (push_v && (!full || pop)) begin
                mem[wp[AW-1:0]] <= push_d;
                wp              <= wp + (AW+1)'(1);
            end
        end
    end
endmodule
